keypad_entry_display: RTL
=========================

Name: keypad_entry_display

Overview:
- Downstream consumer of the 4x3 keypad scanner.
- Takes the scanner's per-frame key code and hit flag, debounces them, and generates one key event per physical press.
- Maintains a 4-digit hex entry register (digit shift-in, E = clear, F = backspace).
- Drives a multiplexed 4-digit seven-segment display from that register.

Parameters:
- STABLE_CNT, 4: consecutive identical frame samples required to accept a press, and no-hit samples required to accept a release (legal range 1..15).
- REFRESH_DIV, 50000: clk cycles per display digit slot (legal range ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- sample_en  input  1  one-clk pulse per completed scanner frame; key_hit/key_code valid on that cycle only
- key_hit  input  1  at least one key detected during the frame
- key_code  input  4  hex code of the detected key (0-9, E, F)
- key_event  output  1  one-clk pulse when a press is accepted
- entry  output  16  entry register; digit3 = [15:12] ... digit0 = [3:0]
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high
- common  output  4  digit select, active-low one-hot; bit i selects digit i

Behaviour:
- Reset (rst_n=0 at a clk edge) dominates all other activity, including mid-debounce and mid-refresh. After reset:
  - entry=16'h0000, key_event=0, debounce state IDLE, both debounce counters 0
  - refresh counter 0, digit index 0, common=4'b1110, seg=7'b0111111 (the "0" pattern)
- Debounce FSM advances only on cycles with sample_en=1; otherwise it holds. States IDLE, CONFIRM, HELD. Registers: cap_code[3:0], cnt.
  - IDLE: if key_hit, cap_code<=key_code, cnt<=1. Then:
    - if STABLE_CNT==1, accept immediately and go to HELD;
    - else go to CONFIRM.
    - No hit: stay in IDLE.
  - CONFIRM:
    - key_hit with key_code==cap_code: cnt<=cnt+1. When cnt+1==STABLE_CNT, accept and go to HELD.
    - key_hit with a different code: restart, cap_code<=key_code, cnt<=1, stay in CONFIRM.
    - No hit: go to IDLE, cnt<=0.
  - HELD:
    - No hit: cnt<=cnt+1. When cnt+1==STABLE_CNT, go to IDLE.
    - Any hit (any code): cnt<=0. A held key or a second key pressed while held never generates a new event.
    - On entering HELD, cnt<=0.
- Accept action is registered. On the clk edge following the accepting sample_en cycle, key_event=1 for exactly one cycle and entry updates on that same edge:
  - code 0-9 (and A-D, if ever presented): entry<={entry[11:0],cap_code}; the old digit3 is discarded.
  - code E: entry<=16'h0000.
  - code F: entry<={4'h0,entry[15:4]}.
- Display refresh, independent of sample_en:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - At wrap, digit index increments mod 4 (3 wraps to 0).
  - On the edge after the index changes, common and seg are registered from the new index and the current entry nibble.
  - Hex decode: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
  - A mid-slot entry change is visible at the next registered update; no glitch to all-off.
- Simultaneous sample_en and refresh wrap: both act independently on the same edge.

Optional Feature:
- Macro LEADING_BLANK_EN.
- Defined:
  - digit i (i=3..1) shows seg=7'b0000000 when its nibble and all higher nibbles are zero;
  - digit0 is never blanked;
  - common still cycles normally.
- Undefined: all four digits are always decoded, so leading zeros display as "0".

Test Plan:
- Reset, then sample_en frames with key_hit=1, key_code=4'h5 held for 4 frames -> one key_event pulse one clk after the 4th sample, entry=16'h0005; 10 further hit frames -> no more events.
- Press 1, 2, 3, 4, 7 (each 4 hit frames + 4 no-hit frames) -> entry sequence 0001, 0012, 0123, 1234, 2347; exactly 5 key_event pulses.
- Bounce: hit 8, 8, no-hit, 8, 8, 8, 8 -> single event only after the final run completes, entry ends in 8; pattern hit 3, 3, 9, 9, 9, 9 -> event with code 9 only.
- With entry=16'h2347: press F -> 0234; press E -> 0000; release shorter than STABLE_CNT between two presses of the same key -> only one event.
- REFRESH_DIV=4, entry=16'h12AF: common cycles 1110, 1101, 1011, 0111 every 4 clks, with seg 1110001, 1110111, 1011011, 0000110; with LEADING_BLANK_EN and entry=16'h0042, digits 3/2 show 0000000.
- Assert rst_n=0 mid-CONFIRM and mid-refresh -> next cycle all reset values; a subsequent 4-frame press gives a normal single event.

Source files
------------

// File: rtl/keypad_entry_display.sv
// keypad_entry_display
//   Consumes per-frame results from the 4x3 keypad scanner. It debounces
//   them into one key event per physical press and keeps a 4-digit hex
//   entry register: digits shift in, E clears, F deletes the last digit.
//   The register is shown on a multiplexed 4-digit seven-segment display.
//
//   Optional feature: define LEADING_BLANK_EN to blank leading zero digits.
//   digit0 always shows.
//
// Ports:
//   clk       system clock (rising edge)
//   rst_n     synchronous active-low reset
//   sample_en one-cycle strobe per completed scanner frame
//   key_hit   key detected in the frame (valid with sample_en)
//   key_code  hex code of the detected key (valid with sample_en)
//   key_event one-cycle pulse per accepted press
//   entry     entry register, digit3 = [15:12] .. digit0 = [3:0]
//   seg       segments {g,f,e,d,c,b,a}, active-high
//   common    digit select, active-low one-hot
module keypad_entry_display #(
  parameter int STABLE_CNT  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_en,
  input  logic        key_hit,
  input  logic [3:0]  key_code,
  output logic        key_event,
  output logic [15:0] entry,
  output logic [6:0]  seg,
  output logic [3:0]  common
);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);
  localparam int         RW     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] RLAST = RW'(REFRESH_DIV - 1);

  state_t      state;
  logic [3:0]  cap_code;
  logic [3:0]  cnt;

  logic [RW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_next;

  function automatic logic [15:0] apply_key(input logic [15:0] e, input logic [3:0] c);
    case (c)
      4'hE:    apply_key = '0;
      4'hF:    apply_key = {4'h0, e[15:4]};
      default: apply_key = {e[11:0], c};
    endcase
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  // Debounce FSM and entry register. The accepting sample updates entry and
  // raises key_event on the same edge; when accepting from CONFIRM the
  // incoming code equals cap_code, so key_code is used directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_code  <= '0;
      cnt       <= '0;
      key_event <= 1'b0;
      entry     <= '0;
    end else begin
      key_event <= 1'b0;
      if (sample_en) begin
        case (state)
          IDLE: begin
            if (key_hit) begin
              cap_code <= key_code;
              if (STABLE == 4'd1) begin
                cnt       <= '0;
                state     <= HELD;
                key_event <= 1'b1;
                entry     <= apply_key(entry, key_code);
              end else begin
                cnt   <= 4'd1;
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (!key_hit) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (key_code != cap_code) begin
              cap_code <= key_code;
              cnt      <= 4'd1;
            end else if ((cnt + 4'd1) == STABLE) begin
              cnt       <= '0;
              state     <= HELD;
              key_event <= 1'b1;
              entry     <= apply_key(entry, key_code);
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          HELD: begin
            if (key_hit) begin
              cnt <= '0;
            end else if ((cnt + 4'd1) == STABLE) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    nibble = entry[3:0];
    blank  = 1'b0;
    case (idx)
      2'd1: nibble = entry[7:4];
      2'd2: nibble = entry[11:8];
      2'd3: nibble = entry[15:12];
      default: nibble = entry[3:0];
    endcase
`ifdef LEADING_BLANK_EN
    case (idx)
      2'd1: blank = (entry[15:4] == 12'h000);
      2'd2: blank = (entry[15:8] == 8'h00);
      2'd3: blank = (entry[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    seg_next = blank ? 7'b0000000 : hex7(nibble);
  end

  // Display refresh. common/seg are re-registered every cycle from the
  // current index and entry, so they trail an index change by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt   <= '0;
      idx    <= '0;
      common <= 4'b1110;
      seg    <= 7'b0111111;
    end else begin
      if (rcnt == RLAST) begin
        rcnt <= '0;
        idx  <= idx + 2'd1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
      common <= ~(4'b0001 << idx);
      seg    <= seg_next;
    end
  end

endmodule
